// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed from a small byte FIFO
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          transmitData,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int               AW         = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]      FULL_COUNT = FIFO_DEPTH[AW:0];
   localparam logic [15:0]      BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateType;

   stateType      state;
   logic [7:0]    fifoMem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW:0]   count;
   logic [7:0]    shiftReg;
   logic [2:0]    bitCnt;
   logic [15:0]   baudCnt;
   logic          baudDone;
   logic          haveData;
   logic          push;
   logic          pop;

   assign haveData   = (count != '0);
   assign baudDone   = (baudCnt == BAUD_LAST);
   assign tx_ready   = (count < FULL_COUNT);
   assign push       = tx_valid && tx_ready;
   // Pops happen only when the line is free: from IDLE, or as the stop bit ends.
   assign pop        = haveData && ((state == IDLE) || (state == STOP && baudDone));
   assign busy       = (state != IDLE) || haveData;
   assign fifo_count = count;

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         fifoMem[wrPtr] <= tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         transmitData <= 1'b1;
         wrPtr        <= '0;
         rdPtr        <= '0;
         count        <= '0;
         shiftReg     <= '0;
         bitCnt       <= '0;
         baudCnt      <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         case (state)
            IDLE: begin
               transmitData <= 1'b1;
               baudCnt      <= '0;
               bitCnt       <= '0;
               if (pop) begin
                  shiftReg     <= fifoMem[rdPtr];
                  transmitData <= 1'b0;
                  state        <= START;
               end
            end
            START: begin
               if (baudDone) begin
                  baudCnt      <= '0;
                  transmitData <= shiftReg[0];
                  state        <= DATA;
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            DATA: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  if (bitCnt == 3'd7) begin
                     bitCnt       <= '0;
                     transmitData <= 1'b1;
                     state        <= STOP;
                  end else begin
                     bitCnt       <= bitCnt + 1'b1;
                     shiftReg     <= shiftReg >> 1;
                     transmitData <= shiftReg[1];
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            STOP: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  if (pop) begin
                     shiftReg     <= fifoMem[rdPtr];
                     transmitData <= 1'b0;
                     state        <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized and directed bench for uart_tx_fifo against a frame-timing model
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       transmitData;
   logic       busy;
   logic [2:0] fifo_count;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .transmitData(transmitData),
      .busy(busy),
      .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         errCnt = 0;
   int         chkCnt = 0;

   // Model: a queue of buffered bytes plus the start edge of the frame on the line.
   logic [7:0] modelQ[$];
   logic [7:0] curByte = 8'h00;
   int         frameStart = 0;
   int         cyc = 0;
   bit         modelActive = 1'b0;
   logic       expLine;
   logic       expReady;
   logic       expBusy;
   logic [2:0] expCount;

   task automatic tick(input logic rstVal, input logic valid, input logic [7:0] data);
      logic [9:0] frame;
      bit         acc;
      bit         ended;
      bit         popNow;
      rst_n    = rstVal;
      tx_valid = valid;
      tx_data  = data;
      @(posedge clk);
      cyc++;
      if (!rstVal) begin
         modelQ.delete();
         modelActive = 1'b0;
      end else begin
         acc    = valid && (modelQ.size() < DEPTH);
         ended  = modelActive && (cyc == frameStart + FRAME);
         popNow = (modelQ.size() > 0) && (!modelActive || ended);
         if (ended) modelActive = 1'b0;
         if (popNow) begin
            curByte     = modelQ.pop_front();
            frameStart  = cyc;
            modelActive = 1'b1;
         end
         if (acc) modelQ.push_back(data);
      end
      frame = {1'b1, curByte, 1'b0};
      if (modelActive) expLine = frame[(cyc - frameStart) / CPB];
      else             expLine = 1'b1;
      expCount = 3'(modelQ.size());
      expReady = (modelQ.size() < DEPTH);
      expBusy  = modelActive || (modelQ.size() != 0);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 8'h55);
         chkCnt++;
         if (transmitData !== 1'b1) begin errCnt++; $display("FAIL reset_line got=%b exp=1", transmitData); end
         chkCnt++;
         if (fifo_count !== 3'd0) begin errCnt++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
         chkCnt++;
         if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errCnt++; $display("FAIL reset_flags ready=%b busy=%b exp ready=1 busy=0", tx_ready, busy);
         end
      end
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b0, 8'h00);
         chkCnt++;
         if (transmitData !== 1'b1 || busy !== 1'b0) begin
            errCnt++; $display("FAIL reset_push_discard line=%b busy=%b exp line=1 busy=0", transmitData, busy);
         end
      end
   endtask

   task automatic test_single_a5();
      logic [9:0] pat;
      logic       samp[44];
      pat = 10'b1101001010;
      tick(1'b1, 1'b1, 8'hA5);
      chkCnt++;
      if (transmitData !== 1'b1 || fifo_count !== 3'd1) begin
         errCnt++; $display("FAIL a5_push line=%b count=%0d exp line=1 count=1", transmitData, fifo_count);
      end
      for (int j = 0; j < 44; j++) begin
         tick(1'b1, 1'b0, 8'h00);
         samp[j] = transmitData;
         chkCnt++;
         if (transmitData !== expLine) begin
            errCnt++; $display("FAIL a5_model cyc=%0d got=%b exp=%b", cyc, transmitData, expLine);
         end
      end
      for (int j = 0; j < 44; j++) begin
         chkCnt++;
         if (samp[j] !== ((j < FRAME) ? pat[j / CPB] : 1'b1)) begin
            errCnt++; $display("FAIL a5_wave idx=%0d got=%b exp=%b", j, samp[j], (j < FRAME) ? pat[j / CPB] : 1'b1);
         end
      end
      chkCnt++;
      if (busy !== 1'b0 || fifo_count !== 3'd0) begin
         errCnt++; $display("FAIL a5_done busy=%b count=%0d exp busy=0 count=0", busy, fifo_count);
      end
   endtask

   task automatic test_overflow();
      for (int v = 1; v <= 6; v++) begin
         tick(1'b1, 1'b1, 8'(v));
         chkCnt++;
         if (fifo_count !== expCount || tx_ready !== expReady) begin
            errCnt++; $display("FAIL ovf_fill v=%0d count=%0d ready=%b exp count=%0d ready=%b", v, fifo_count, tx_ready, expCount, expReady);
         end
      end
      chkCnt++;
      if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin
         errCnt++; $display("FAIL ovf_full count=%0d ready=%b exp count=4 ready=0", fifo_count, tx_ready);
      end
      for (int j = 0; j < 5 * FRAME + 10; j++) begin
         tick(1'b1, 1'b0, 8'h00);
         chkCnt++;
         if (transmitData !== expLine || fifo_count !== expCount) begin
            errCnt++; $display("FAIL ovf_drain cyc=%0d line=%b count=%0d exp line=%b count=%0d", cyc, transmitData, fifo_count, expLine, expCount);
         end
      end
      chkCnt++;
      if (busy !== 1'b0 || fifo_count !== 3'd0) begin
         errCnt++; $display("FAIL ovf_done busy=%b count=%0d exp busy=0 count=0", busy, fifo_count);
      end
   endtask

   task automatic test_zero_ff();
      logic want;
      tick(1'b1, 1'b1, 8'h00);
      for (int j = 0; j < 2 * FRAME + 4; j++) begin
         if (j == 0) tick(1'b1, 1'b1, 8'hFF);
         else        tick(1'b1, 1'b0, 8'h00);
         want = (j < 9 * CPB) ? 1'b0 : (j < FRAME) ? 1'b1 : (j < FRAME + CPB) ? 1'b0 : 1'b1;
         chkCnt++;
         if (transmitData !== want) begin
            errCnt++; $display("FAIL zeroff_wave idx=%0d got=%b exp=%b", j, transmitData, want);
         end
         chkCnt++;
         if (transmitData !== expLine) begin
            errCnt++; $display("FAIL zeroff_model cyc=%0d got=%b exp=%b", cyc, transmitData, expLine);
         end
      end
   endtask

   task automatic test_reset_midframe();
      tick(1'b1, 1'b1, 8'h3C);
      for (int j = 0; j <= 17; j++) begin
         tick(1'b1, 1'b0, 8'h00);
         chkCnt++;
         if (transmitData !== expLine) begin
            errCnt++; $display("FAIL midrst_pre cyc=%0d got=%b exp=%b", cyc, transmitData, expLine);
         end
      end
      tick(1'b0, 1'b0, 8'h00);
      chkCnt++;
      if (transmitData !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) begin
         errCnt++; $display("FAIL midrst_edge line=%b count=%0d busy=%b exp line=1 count=0 busy=0", transmitData, fifo_count, busy);
      end
      for (int j = 0; j < 60; j++) begin
         tick(1'b1, 1'b0, 8'h00);
         chkCnt++;
         if (transmitData !== 1'b1 || busy !== 1'b0) begin
            errCnt++; $display("FAIL midrst_after cyc=%0d line=%b busy=%b exp line=1 busy=0", cyc, transmitData, busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      int guard;
      tick(1'b1, 1'b1, 8'h96);
      tick(1'b1, 1'b1, 8'h4B);
      guard = 0;
      while (cyc < frameStart + FRAME - 1 && guard < 2 * FRAME) begin
         tick(1'b1, 1'b0, 8'h00);
         guard++;
      end
      chkCnt++;
      if (guard >= 2 * FRAME || fifo_count !== 3'd1) begin
         errCnt++; $display("FAIL b2b_before guard=%0d count=%0d exp count=1", guard, fifo_count);
      end
      tick(1'b1, 1'b1, 8'hE1);
      chkCnt++;
      if (fifo_count !== 3'd1 || transmitData !== 1'b0) begin
         errCnt++; $display("FAIL b2b_boundary count=%0d line=%b exp count=1 line=0", fifo_count, transmitData);
      end
      for (int j = 0; j < 2 * FRAME + 5; j++) begin
         tick(1'b1, 1'b0, 8'h00);
         chkCnt++;
         if (transmitData !== expLine || fifo_count !== expCount) begin
            errCnt++; $display("FAIL b2b_model cyc=%0d line=%b count=%0d exp line=%b count=%0d", cyc, transmitData, fifo_count, expLine, expCount);
         end
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 400 + 6 * FRAME; j++) begin
         if (j < 400) tick(1'b1, ($urandom_range(0, 3) == 0), 8'($urandom));
         else         tick(1'b1, 1'b0, 8'($urandom));
         chkCnt++;
         if (transmitData !== expLine || fifo_count !== expCount || tx_ready !== expReady || busy !== expBusy) begin
            errCnt++;
            $display("FAIL rand cyc=%0d line=%b count=%0d ready=%b busy=%b exp line=%b count=%0d ready=%b busy=%b",
                     cyc, transmitData, fifo_count, tx_ready, busy, expLine, expCount, expReady, expBusy);
         end
      end
      chkCnt++;
      if (busy !== 1'b0 || transmitData !== 1'b1) begin
         errCnt++; $display("FAIL rand_done busy=%b line=%b exp busy=0 line=1", busy, transmitData);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      test_reset();
      test_single_a5();
      test_overflow();
      test_zero_ff();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
